fetch_unit: RTL
===============

# fetch_unit

Parametrised decoupled instruction-fetch front end for the pipelined RV32I core. Owns the fetch PC, issues one instruction-memory read at a time, and buffers returned instructions in a small queue. The queue drains into decode through a valid/ready handshake. Execute can redirect fetch at any time, which flushes all in-flight work; static branch prediction is available as a compile-time option.

## Interface
- QUEUE_DEPTH, 4: number of instruction-queue entries; power of two, ≥2.
- RESET_PC, 32'h00000060: fetch PC loaded on reset.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_read  out  1  read request; once asserted, held with a stable address until imem_resp.
- imem_address  out  32  word-aligned fetch address.
- imem_resp  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- redirect  in  1  execute-stage redirect (mispredict, jump, or trap); highest priority.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- fd_valid  out  1  queue head valid.
- fd_ready  in  1  decode accepts the head this cycle.
- fd_pc  out  32  PC of the head instruction.
- fd_pc_plus4  out  32  fd_pc + 4.
- fd_instruction  out  32  head instruction word.
- fd_pred_taken  out  1  fetch predicted the head as taken.
- fd_pred_target  out  32  predicted target; equals fd_pc_plus4 when not taken.

## Operation
- State machine has two states:
  - FETCH: normal operation.
  - DRAIN: a redirect arrived while a request was outstanding; the response still pending belongs to the old path.
- Occupancy is tracked in `count`, a register of width $clog2(QUEUE_DEPTH+1). `outstanding` is 1 while imem_read is asserted.
- FETCH behaviour:
  - imem_read = 1 when count + outstanding < QUEUE_DEPTH, or when a request is already outstanding.
  - imem_address = fetch_pc.
  - On imem_resp, push {fetch_pc, imem_rdata, pred_taken, pred_target} and load fetch_pc ← next_pc.
- next_pc = fetch_pc + 4, unless prediction is enabled (see Configuration). Addition is 32-bit and wraps modulo 2^32.
- A pop occurs when fd_valid && fd_ready. Push and pop in the same cycle leave count unchanged. Push and pop are both permitted when count == QUEUE_DEPTH−1.
- The issue rule guarantees no push occurs when the queue is full. A push into a full queue is an assertion failure.
- Redirect handling:
  - The queue is flushed: count ← 0 and pointers ← 0. Any pop in that cycle is discarded.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding and imem_resp = 0, go to DRAIN.
  - If imem_resp = 1 in the same cycle, drop that data and stay in FETCH.
- DRAIN:
  - imem_read stays asserted with the old address.
  - On imem_resp the data is discarded and the state returns to FETCH.
  - A further redirect while in DRAIN only updates fetch_pc.
- Reset values: state = FETCH, fetch_pc = RESET_PC, count = 0, imem_read = 0 in the reset cycle, fd_valid = 0, fd_pred_taken = 0. Pointers are 0 and the head data outputs are 0.
- Reset asserted mid-request abandons the request; the memory side must tolerate imem_read dropping.

## Timing
- First request is issued in the cycle after rst deasserts.
- Response at cycle N → fd_valid at N+1. There is no same-cycle bypass.
- Back-to-back issue: when a response arrives and space remains, the next request address appears in cycle N+1.
- Redirect at cycle R: fd_valid = 0 at R+1. A new-path request is issued at R+1 if the state is FETCH.
- fd_* outputs are registered-queue reads and stay stable while fd_valid && !fd_ready.

## Configuration
- FETCH_PREDICT_EN defined:
  - Static prediction is applied to imem_rdata on response.
  - op_br with instruction[31] = 1 (backward branch): next_pc = fetch_pc + b_imm, pred_taken = 1.
  - op_jal: next_pc = fetch_pc + j_imm, pred_taken = 1.
  - Otherwise pc + 4, not taken.
  - Execute redirects on mismatch.
- FETCH_PREDICT_EN undefined: next_pc = fetch_pc + 4 always; fd_pred_taken tied 0 and fd_pred_target = fd_pc_plus4. No immediate-decode logic is synthesised.

## Structure
- The fetch_entry_t packed struct (pc, instruction, pred_taken, pred_target) and the fetch state enum belong in rv32i_types. Opcode constants op_br and op_jal already live there.
- Sub-module fetch_queue: circular FIFO parametrised by QUEUE_DEPTH and carrying fetch_entry_t, with push, pop, flush, count, full and empty.

## Test plan
- Reset then fd_ready = 1 and 1-cycle memory: addresses 0x60, 0x64, 0x68…; fd_pc matches the address; fd_valid one cycle after each resp.
- fd_ready = 0 with QUEUE_DEPTH = 4: exactly 4 pushes, then imem_read = 0. Releasing fd_ready pops 0x60 first and fetching resumes.
- Redirect to 0x200 while a request is outstanding, with resp 2 cycles later: that response is dropped, the next request address is 0x200, and no old-path entry reaches decode.
- Redirect to 0x203 in the same cycle as imem_resp: data dropped, next address 0x200, count = 0.
- FETCH_PREDICT_EN, fetch at 0x80 returns a backward branch with b_imm = −16: next address 0x70; fd_pred_taken = 1 and fd_pred_target = 0x70. Without the macro the next address is 0x84.
- rst asserted during DRAIN: next cycle state = FETCH, fetch_pc = 0x60, fd_valid = 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I opcodes, fetch queue entry and fetch FSM state types
package rv32i_types;
  localparam logic [6:0] op_br  = 7'b1100011;
  localparam logic [6:0] op_jal = 7'b1101111;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;
  typedef enum logic {FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch entries (push, pop, flush, count, full, empty); head reads 0 when empty
module fetch_queue
  import rv32i_types::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  fetch_entry_t                     din,
  output fetch_entry_t                     dout,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count,
  output logic                             full,
  output logic                             empty
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  fetch_entry_t mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign full  = count == CW'(QUEUE_DEPTH);
  assign empty = count == '0;
  assign dout  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled RV32I fetch front end (one outstanding imem read, queue to decode, redirect flush); FETCH_PREDICT_EN enables static prediction
module fetch_unit
  import rv32i_types::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc_plus4,
  output logic [31:0] fd_instruction,
  output logic        fd_pred_taken,
  output logic [31:0] fd_pred_target
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  fetch_state_t state, state_next;
  logic [31:0] fetch_pc, req_addr, pred_target;
  logic outstanding_q, pred_taken, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t entry, head;
  assign imem_read    = !rst && (outstanding_q || (state == FETCH && count < CW'(QUEUE_DEPTH)));
  assign imem_address = outstanding_q ? req_addr : fetch_pc;
  assign push         = state == FETCH && imem_read && imem_resp && !redirect;
  assign pop          = fd_valid && fd_ready && !redirect;
  always_comb state_next = (imem_read && !imem_resp && (redirect || state == DRAIN)) ? DRAIN : FETCH;
`ifdef FETCH_PREDICT_EN
  logic [31:0] b_imm, j_imm;
  logic [6:0] opcode;
  always_comb begin
    opcode      = imem_rdata[6:0];
    b_imm       = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    j_imm       = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
    pred_taken  = (opcode == op_br && imem_rdata[31]) || opcode == op_jal;
    pred_target = fetch_pc + (opcode == op_jal ? j_imm : pred_taken ? b_imm : 32'd4);
  end
`else
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = fetch_pc + 32'd4;
  end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state         <= FETCH;
      fetch_pc      <= RESET_PC;
      req_addr      <= RESET_PC;
      outstanding_q <= 1'b0;
    end else begin
      state         <= state_next;
      outstanding_q <= imem_read && !imem_resp;
      req_addr      <= imem_address;
      fetch_pc      <= redirect ? (redirect_pc & ~32'h3) : push ? pred_target : fetch_pc;
    end
  always_ff @(posedge clk)
    if (!rst) assert (!(push && full));
  assign entry = '{pc: fetch_pc, instruction: imem_rdata, pred_taken: pred_taken, pred_target: pred_target};
  fetch_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect),
    .din(entry), .dout(head), .count(count), .full(full), .empty(empty)
  );
  assign fd_valid       = !empty;
  assign fd_pc          = head.pc;
  assign fd_pc_plus4    = head.pc + 32'd4;
  assign fd_instruction = head.instruction;
  assign fd_pred_taken  = head.pred_taken;
  assign fd_pred_target = head.pred_taken ? head.pred_target : fd_pc_plus4;
endmodule
